press_gen: RTL and testbench

PRESS_GEN -- requirements
Module: press_gen

---
 rtl/press_gen_pkg.sv | 26 ++
 rtl/press_gen_cycle_timer.sv | 28 ++
 rtl/press_gen.sv | 132 +++++++++++++
 tb/tb_press_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/press_gen_pkg.sv
// Shared types and default constants for the button-press generator.
package press_gen_pkg;

  // Press sequencer states: waiting, key held down, forced release gap.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Default timing and queue depth.
  localparam int DEF_HOLD_CYCLES = 5;
  localparam int DEF_GAP_CYCLES  = 3;
  localparam int DEF_MAX_PEND    = 3;

  // Larger of two integers, for sizing the shared cycle timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Timer width that can hold the longer of the two phase lengths.
  function automatic int timer_width(input int hold_cycles, input int gap_cycles);
    return $clog2(max_int(hold_cycles, gap_cycles) + 1);
  endfunction

endpackage

// File: rtl/press_gen_cycle_timer.sv
// Loadable down-counter that flags when the current phase has reached its
// final cycle. It stops at zero instead of wrapping.
module cycle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load on phase entry, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/press_gen.sv
// Emulated push-button generator. Each trig request produces one key press:
// key_out held high for HOLD_CYCLES, then forced low for GAP_CYCLES.
// Requests that arrive while a press is running are queued up to MAX_PEND.
// Requests beyond that are discarded, and drop pulses for one cycle.
//
// Request semantics: trig is a fire-and-forget strobe with no ready signal.
// Every cycle it is sampled high counts as exactly one request. The request
// is either accepted (started or queued) or discarded with a drop pulse on
// the following cycle.
module press_gen
  import press_gen_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int MAX_PEND    = DEF_MAX_PEND
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          trig,
  output logic                          key_out,
  output logic                          busy,
  output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt,
  output logic                          drop,
  output state_t                        state_dbg
);

  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int TW = timer_width(HOLD_CYCLES, GAP_CYCLES);

  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PEND);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  state_t         state;
  state_t         state_nxt;
  logic           timer_zero;
  logic           timer_load;
  logic [TW-1:0]  timer_val;
  logic           key_nxt;
  logic           drop_nxt;
  logic [PW-1:0]  pend_nxt;
  logic           gap_last;
  logic           queue_full;

  // The final GAP cycle is where a queued press (or a fresh trig) hands over
  // straight into the next HOLD with no idle cycle in between.
  assign gap_last   = (state == GAP) && timer_zero;
  assign queue_full = (pend_cnt == PEND_MAX);

  cycle_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: phases advance when the timer reports the last cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (trig) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (timer_zero) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (timer_zero) begin
          state_nxt = (trig || (pend_cnt != '0)) ? HOLD : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs and queue bookkeeping for the upcoming cycle.
  always_comb begin
    key_nxt    = (state_nxt == HOLD);
    timer_load = (state_nxt != state) && (state_nxt != IDLE);
    timer_val  = (state_nxt == HOLD) ? HOLD_LOAD : GAP_LOAD;
    pend_nxt   = pend_cnt;
    drop_nxt   = 1'b0;
    if (gap_last) begin
      // A trig on the final gap cycle cancels against the queued press that
      // starts now. It never drops, because the consume frees a slot.
      if (!trig && (pend_cnt != '0)) begin
        pend_nxt = pend_cnt - 1'b1;
      end
    end else if (trig && (state != IDLE)) begin
      if (queue_full) begin
        drop_nxt = 1'b1;
      end else begin
        pend_nxt = pend_cnt + 1'b1;
      end
    end
  end

  // Registered outputs, so key_out has no combinational path from trig.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out  <= 1'b0;
      pend_cnt <= '0;
      drop     <= 1'b0;
    end else begin
      key_out  <= key_nxt;
      pend_cnt <= pend_nxt;
      drop     <= drop_nxt;
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_press_gen.sv
// Testbench for press_gen. It uses a schedule-based reference model: each
// accepted request is assigned a start cycle, and all outputs are derived
// from that list of press start times.
`timescale 1ns/1ps
module tb_press_gen;
  import press_gen_pkg::*;

  localparam int H  = 5;
  localparam int G  = 3;
  localparam int MP = 3;
  localparam int PW = $clog2(MP + 1);

  // ---------------- clock / reset / DUT ----------------
  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          trig  = 1'b0;
  logic          key_out;
  logic          busy;
  logic [PW-1:0] pend_cnt;
  logic          drop;
  state_t        state_dbg;

  always #5 clk = ~clk;

  press_gen #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .MAX_PEND    (MP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig      (trig),
    .key_out   (key_out),
    .busy      (busy),
    .pend_cnt  (pend_cnt),
    .drop      (drop),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: start cycle of every press not yet finished.
  int starts[$];
  int last_start    = -1000;
  bit drop_exp_next = 1'b0;
  int cyc           = 0;

  // Observation counters, written only by the compare process.
  int   presses  = 0;
  int   drops    = 0;
  logic prev_key = 1'b0;

  function automatic int count_after(input int t);
    int c = 0;
    foreach (starts[i]) if (starts[i] > t) c++;
    return c;
  endfunction

  // Compare process: one sample per cycle, mid-cycle on the falling edge.
  always @(negedge clk) begin : compare
    int e_key;
    int e_busy;
    int e_pend;
    int e_drop;
    int ns;
    e_key  = 0;
    e_busy = 0;
    e_pend = 0;
    e_drop = 0;
    if (!rst_n) begin
      starts.delete();
      last_start    = -1000;
      drop_exp_next = 1'b0;
    end else begin
      while (starts.size() > 0 && starts[0] + H + G <= cyc) void'(starts.pop_front());
      foreach (starts[i]) begin
        if (starts[i] <= cyc && cyc < starts[i] + H)     e_key  = 1;
        if (starts[i] <= cyc && cyc < starts[i] + H + G) e_busy = 1;
        if (starts[i] > cyc)                             e_pend++;
      end
      e_drop = drop_exp_next ? 1 : 0;
    end
    check("key_out",  32'(key_out),  32'(e_key));
    check("busy",     32'(busy),     32'(e_busy));
    check("pend_cnt", 32'(pend_cnt), 32'(e_pend));
    check("drop",     32'(drop),     32'(e_drop));
    if (key_out === 1'b1 && prev_key !== 1'b1) presses++;
    if (drop === 1'b1) drops++;
    prev_key = key_out;
    // Apply this cycle's request to the schedule.
    drop_exp_next = 1'b0;
    if (rst_n && trig) begin
      // Pending presses after the next edge; a start at cyc+1 frees its slot.
      if (count_after(cyc + 1) < MP) begin
        ns = (cyc + 1 > last_start + H + G) ? cyc + 1 : last_start + H + G;
        starts.push_back(ns);
        last_start = ns;
      end else begin
        drop_exp_next = 1'b1;
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  // Drive trig for the cycle that starts at the next rising edge.
  task automatic step(input bit t);
    @(posedge clk);
    #1;
    trig = t;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0);
  endtask

  // ---------------- stimulus ----------------
  int p0;
  int d0;
  int maxp;
  int pct;
  int dens[4] = '{10, 35, 65, 95};

  initial begin
    rst_n = 1'b0;
    trig  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_key",   32'(key_out),   0);
    check("rst_busy",  32'(busy),      0);
    check("rst_pend",  32'(pend_cnt),  0);
    check("rst_drop",  32'(drop),      0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));

    // Single press right on the first cycle out of reset.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    trig  = 1'b1;
    #3;
    check("single_c0_key", 32'(key_out), 0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b0);
      #3;
      check("single_key",  32'(key_out),  (i >= 1 && i <= 5) ? 1 : 0);
      check("single_busy", 32'(busy),     (i <= 8) ? 1 : 0);
      check("single_pend", 32'(pend_cnt), 0);
    end

    // Four back-to-back requests: all queued, none dropped.
    p0 = presses; d0 = drops; maxp = 0;
    for (int i = 0; i < 4; i++) step(1'b1);
    for (int i = 0; i < 40; i++) begin
      step(1'b0);
      #3;
      if (int'(pend_cnt) > maxp) maxp = int'(pend_cnt);
    end
    check("burst4_presses", 32'(presses - p0), 4);
    check("burst4_drops",   32'(drops - d0),   0);
    check("burst4_maxpend", 32'(maxp),         3);

    // Six back-to-back requests: queue saturates, two drops.
    p0 = presses; d0 = drops; maxp = 0;
    for (int i = 0; i < 6; i++) step(1'b1);
    for (int i = 0; i < 45; i++) begin
      step(1'b0);
      #3;
      if (int'(pend_cnt) > maxp) maxp = int'(pend_cnt);
    end
    check("burst6_presses", 32'(presses - p0), 4);
    check("burst6_drops",   32'(drops - d0),   2);
    check("burst6_maxpend", 32'(maxp),         3);

    // pend_cnt=1 and trig on the final gap cycle.
    p0 = presses; d0 = drops;
    step(1'b1);
    step(1'b1);
    idle(6);
    step(1'b1);
    #3;
    check("lastgap1_pend_before", 32'(pend_cnt), 1);
    check("lastgap1_busy_before", 32'(busy),     1);
    check("lastgap1_key_before",  32'(key_out),  0);
    step(1'b0);
    #3;
    check("lastgap1_key",  32'(key_out),  1);
    check("lastgap1_pend", 32'(pend_cnt), 1);
    check("lastgap1_drop", 32'(drop),     0);
    idle(30);
    check("lastgap1_presses", 32'(presses - p0), 3);
    check("lastgap1_drops",   32'(drops - d0),   0);

    // Full queue and trig on the final gap cycle: accepted, no drop.
    p0 = presses; d0 = drops;
    for (int i = 0; i < 4; i++) step(1'b1);
    idle(4);
    step(1'b1);
    #3;
    check("lastgapfull_pend_before", 32'(pend_cnt), 3);
    step(1'b0);
    #3;
    check("lastgapfull_drop", 32'(drop),     0);
    check("lastgapfull_pend", 32'(pend_cnt), 3);
    check("lastgapfull_key",  32'(key_out),  1);
    idle(50);
    check("lastgapfull_presses", 32'(presses - p0), 5);
    check("lastgapfull_drops",   32'(drops - d0),   0);

    // Reset in the third HOLD cycle with two presses queued.
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    #3;
    check("midrst_pend_before", 32'(pend_cnt), 2);
    check("midrst_key_before",  32'(key_out),  1);
    rst_n = 1'b0;
    #1;
    check("midrst_key",  32'(key_out),  0);
    check("midrst_busy", 32'(busy),     0);
    check("midrst_pend", 32'(pend_cnt), 0);
    idle(2);
    rst_n = 1'b1;
    p0 = presses;
    idle(25);
    check("midrst_no_activity", 32'(presses - p0), 0);

    // Randomized traffic at several densities, with occasional resets.
    for (int b = 0; b < 8; b++) begin
      pct = dens[b % 4];
      for (int i = 0; i < 300; i++) begin
        step($urandom_range(0, 99) < pct);
        if ($urandom_range(0, 249) == 0) begin
          rst_n = 1'b0;
          repeat ($urandom_range(1, 3)) step($urandom_range(0, 1) == 1);
          rst_n = 1'b1;
        end
      end
    end
    idle(40);
    check("final_idle_busy", 32'(busy),     0);
    check("final_idle_pend", 32'(pend_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
